// File: rtl/text_console.sv
// text_console: character-stream front end for a COLS x ROWS text-mode VRAM.
// Accepts CPU bytes, keeps a cursor, writes glyph codes through the VRAM
// write port and handles CR/LF/BS/FF. Scrolling is done by rotating top_row,
// which the display stage adds (mod ROWS) to its row index.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_data   byte stream in; accepted when in_valid && in_ready
//   in_ready            high only while idle
//   v_ada, v_cea, v_din VRAM write port (address, enable, data)
//   top_row             physical VRAM row shown as screen row 0
//   cur_col, cur_row    cursor position (logical row)
//   busy                high in any state other than IDLE
module text_console #(
  parameter int unsigned COLS  = 60,
  parameter int unsigned ROWS  = 17,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [9:0] v_ada,
  output logic       v_cea,
  output logic [7:0] v_din,
  output logic [4:0] top_row,
  output logic [5:0] cur_col,
  output logic [4:0] cur_row,
  output logic       busy
);

  localparam int unsigned NCELLS    = COLS * ROWS;
  localparam logic [9:0]  LAST_CELL = 10'(NCELLS - 1);
  localparam logic [9:0]  COLS_W    = 10'(COLS);
  localparam logic [5:0]  LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_IDLE   = 2'd1,
    S_WRITE  = 2'd2,
    S_SCROLL = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        scroll_q, scroll_d;
  logic        in_ready_q, in_ready_d;
  logic        v_cea_q, v_cea_d;
  logic [9:0]  v_ada_q, v_ada_d;
  logic [7:0]  v_din_q, v_din_d;
  logic [4:0]  top_row_q, top_row_d;
  logic [5:0]  cur_col_q, cur_col_d;
  logic [4:0]  cur_row_q, cur_row_d;
  logic        busy_q, busy_d;

  // Physical address of a logical cell; the 6-bit sum cannot overflow.
  function automatic logic [9:0] cell_addr(input logic [4:0] top,
                                           input logic [4:0] row,
                                           input logic [5:0] col);
    logic [5:0] phys;
    phys = {1'b0, top} + {1'b0, row};
    if (phys >= 6'(ROWS)) phys = phys - 6'(ROWS);
    return 10'(phys) * COLS_W + 10'(col);
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    scroll_d   = scroll_q;
    in_ready_d = in_ready_q;
    v_cea_d    = 1'b0;
    v_ada_d    = v_ada_q;
    v_din_d    = v_din_q;
    top_row_d  = top_row_q;
    cur_col_d  = cur_col_q;
    cur_row_d  = cur_row_q;

    case (state_q)
      S_CLEAR: begin
        v_cea_d = 1'b1;
        v_ada_d = cnt_q;
        v_din_d = BLANK;
        if (cnt_q == LAST_CELL) begin
          state_d    = S_IDLE;
          in_ready_d = 1'b1;
          cnt_d      = '0;
          top_row_d  = '0;
          cur_col_d  = '0;
          cur_row_d  = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end

      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          case (in_data)
            CH_CR: cur_col_d = '0;
            CH_LF: begin
              cur_col_d = '0;
              if (cur_row_q != LAST_ROW) begin
                cur_row_d = cur_row_q + 5'd1;
              end else begin
                state_d    = S_SCROLL;
                cnt_d      = '0;
                in_ready_d = 1'b0;
              end
            end
            CH_BS: begin
              if (cur_col_q != '0) begin
                cur_col_d  = cur_col_q - 6'd1;
                v_cea_d    = 1'b1;
                v_ada_d    = cell_addr(top_row_q, cur_row_q, cur_col_q - 6'd1);
                v_din_d    = BLANK;
                scroll_d   = 1'b0;
                state_d    = S_WRITE;
                in_ready_d = 1'b0;
              end
            end
            CH_FF: begin
              state_d    = S_CLEAR;
              cnt_d      = '0;
              in_ready_d = 1'b0;
            end
            default: begin
              // Write at the pre-advance cursor, then advance.
              v_cea_d    = 1'b1;
              v_ada_d    = cell_addr(top_row_q, cur_row_q, cur_col_q);
              v_din_d    = in_data;
              state_d    = S_WRITE;
              in_ready_d = 1'b0;
              scroll_d   = 1'b0;
              if (cur_col_q == LAST_COL) begin
                cur_col_d = '0;
                if (cur_row_q != LAST_ROW) cur_row_d = cur_row_q + 5'd1;
                else scroll_d = 1'b1;
              end else begin
                cur_col_d = cur_col_q + 6'd1;
              end
            end
          endcase
        end
      end

      S_WRITE: begin
        if (scroll_q) begin
          state_d = S_SCROLL;
          cnt_d   = '0;
        end else begin
          state_d    = S_IDLE;
          in_ready_d = 1'b1;
        end
      end

      S_SCROLL: begin
        // cnt 0..COLS-1 blank the old top row, COLS rotates top_row,
        // COLS+1 hands back to IDLE.
        if (cnt_q < COLS_W) begin
          v_cea_d = 1'b1;
          v_ada_d = cell_addr(top_row_q, 5'd0, 6'(cnt_q));
          v_din_d = BLANK;
          cnt_d   = cnt_q + 10'd1;
        end else if (cnt_q == COLS_W) begin
          top_row_d = (top_row_q == LAST_ROW) ? 5'd0 : top_row_q + 5'd1;
          cnt_d     = cnt_q + 10'd1;
        end else begin
          state_d    = S_IDLE;
          in_ready_d = 1'b1;
          cnt_d      = '0;
        end
      end

      default: state_d = S_CLEAR;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      cnt_q      <= '0;
      scroll_q   <= 1'b0;
      in_ready_q <= 1'b0;
      v_cea_q    <= 1'b0;
      v_ada_q    <= '0;
      v_din_q    <= '0;
      top_row_q  <= '0;
      cur_col_q  <= '0;
      cur_row_q  <= '0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      scroll_q   <= scroll_d;
      in_ready_q <= in_ready_d;
      v_cea_q    <= v_cea_d;
      v_ada_q    <= v_ada_d;
      v_din_q    <= v_din_d;
      top_row_q  <= top_row_d;
      cur_col_q  <= cur_col_d;
      cur_row_q  <= cur_row_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready = in_ready_q;
  assign v_cea    = v_cea_q;
  assign v_ada    = v_ada_q;
  assign v_din    = v_din_q;
  assign top_row  = top_row_q;
  assign cur_col  = cur_col_q;
  assign cur_row  = cur_row_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: a screen-level model predicts the ordered stream of
// VRAM writes and the cursor/top_row, checked every cycle; directed literals
// pin latency, reset and boundary behaviour.
module tb_text_console;

  localparam int         COLS  = 60;
  localparam int         ROWS  = 17;
  localparam logic [7:0] BLANK = 8'h20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [9:0] v_ada;
  logic       v_cea;
  logic [7:0] v_din;
  logic [4:0] top_row;
  logic [5:0] cur_col;
  logic [4:0] cur_row;
  logic       busy;

  text_console dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .v_ada(v_ada), .v_cea(v_cea), .v_din(v_din),
    .top_row(top_row), .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t e_w;
  int  wr_log[$];
  int  wr_cnt = 0;
  int  checks = 0;
  int  failures = 0;
  int  mcol = 0, mrow = 0, mtop = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Screen model
  function automatic int maddr(input int r, input int c);
    return ((mtop + r) % ROWS) * COLS + c;
  endfunction

  task automatic push(input int a, input logic [7:0] d);
    wr_t w;
    w.a = 10'(a);
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic m_newline();
    mcol = 0;
    if (mrow < ROWS - 1) mrow++;
    else begin
      for (int i = 0; i < COLS; i++) push(mtop * COLS + i, BLANK);
      mtop = (mtop + 1) % ROWS;
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < COLS * ROWS; i++) push(i, BLANK);
    mcol = 0; mrow = 0; mtop = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    case (b)
      8'h0D: mcol = 0;
      8'h0A: m_newline();
      8'h08: if (mcol > 0) begin mcol--; push(maddr(mrow, mcol), BLANK); end
      8'h0C: m_clear();
      default: begin
        push(maddr(mrow, mcol), b);
        mcol++;
        if (mcol == COLS) m_newline();
      end
    endcase
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_vs_ready", int'(busy), int'(!in_ready));
      if (v_cea) begin
        wr_cnt++;
        wr_log.push_back(int'(v_ada));
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                   v_ada, v_din);
        end else begin
          e_w = exp_q.pop_front();
          chk("wr_addr", int'(v_ada), int'(e_w.a));
          chk("wr_data", int'(v_din), int'(e_w.d));
        end
      end
      if (in_ready) begin
        chk("cur_col", int'(cur_col), mcol);
        chk("cur_row", int'(cur_row), mrow);
        chk("top_row", int'(top_row), mtop);
      end
    end
  end

  // Present a byte and hold it until accepted; optionally scramble data
  // while not ready and keep in_valid high afterwards.
  task automatic send(input logic [7:0] b, input bit hold, input bit toggle);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready) begin
      if (toggle) in_data = 8'($urandom);
      @(negedge clk);
      n++;
      if (n > 3000) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: got in_ready 0 expected 1 within 3000 cycles");
        in_valid = 1'b0;
        return;
      end
    end
    in_data = b;
    @(posedge clk);
    #1;
    model_byte(b);
    if (!hold) in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #1;
      if (in_ready) return;
    end
    checks++;
    failures++;
    $display("FAIL %s_timeout: got in_ready 0 expected 1 within 3000 cycles", name);
  endtask

  function automatic int last_wr(input int back);
    if (wr_log.size() <= back) return -1;
    return wr_log[wr_log.size() - 1 - back];
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before 400us");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int base_wr;
    bit hit;

    // Reset values
    #2 rst_n = 1'b0;
    #10;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_v_cea", int'(v_cea), 0);
    chk("rst_v_ada", int'(v_ada), 0);
    chk("rst_v_din", int'(v_din), 0);
    chk("rst_top_row", int'(top_row), 0);
    chk("rst_cur_col", int'(cur_col), 0);
    chk("rst_cur_row", int'(cur_row), 0);
    chk("rst_busy", int'(busy), 1);

    // Power-up clear
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    m_clear();
    base = wr_log.size();
    @(negedge clk);
    #1;
    chk("first_clear_cea", int'(v_cea), 1);
    chk("first_clear_ada", int'(v_ada), 0);
    wait_idle("clear");
    chk("clear_count", wr_log.size() - base, 1020);
    chk("clear_last_addr", last_wr(0), 1019);
    chk("clear_top", int'(top_row), 0);
    chk("clear_col", int'(cur_col), 0);

    // Printable latency, BS, CR
    send(8'h41, 1'b0, 1'b0);
    chk("A_cea_n1", int'(v_cea), 1);
    chk("A_ada_n1", int'(v_ada), 0);
    chk("A_din_n1", int'(v_din), 8'h41);
    chk("A_ready_n1", int'(in_ready), 0);
    chk("A_col_n1", int'(cur_col), 1);
    @(negedge clk);
    chk("A_ready_n2", int'(in_ready), 1);
    send(8'h42, 1'b0, 1'b0);
    wait_idle("B");
    chk("B_addr", last_wr(0), 1);
    chk("B_col", int'(cur_col), 2);
    send(8'h08, 1'b0, 1'b0);
    wait_idle("BS");
    chk("BS_addr", last_wr(0), 1);
    chk("BS_col", int'(cur_col), 1);
    base_wr = wr_cnt;
    send(8'h0D, 1'b0, 1'b0);
    send(8'h08, 1'b0, 1'b0);
    wait_idle("CR_BS");
    chk("CR_BS_no_write", wr_cnt - base_wr, 0);
    chk("CR_BS_col", int'(cur_col), 0);

    // Fill the bottom row and wrap into the first scroll
    for (int i = 0; i < 16; i++) send(8'h0A, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) send(8'h58, 1'b0, 1'b0);
    wait_idle("fill");
    chk("fill_last_char", last_wr(60), 1019);
    chk("scroll1_first", last_wr(59), 0);
    chk("scroll1_last", last_wr(0), 59);
    chk("scroll1_top", int'(top_row), 1);
    chk("scroll1_row", int'(cur_row), 16);
    chk("scroll1_col", int'(cur_col), 0);
    send(8'h58, 1'b0, 1'b0);
    wait_idle("X_after_scroll");
    chk("X_after_scroll_addr", last_wr(0), 0);

    // top_row wrap
    for (int i = 0; i < 15; i++) send(8'h0A, 1'b0, 1'b0);
    wait_idle("lf15");
    chk("top_16", int'(top_row), 16);
    base = wr_log.size();
    send(8'h0A, 1'b0, 1'b0);
    wait_idle("wrap");
    chk("wrap_first", (wr_log.size() > base) ? wr_log[base] : -1, 960);
    chk("wrap_last", last_wr(0), 1019);
    chk("wrap_count", wr_log.size() - base, 60);
    chk("wrap_top", int'(top_row), 0);
    for (int i = 0; i < 16; i++) send(8'h0A, 1'b0, 1'b0);
    wait_idle("lf16");
    chk("top_16_again", int'(top_row), 16);

    // FF mid-stream with in_valid held high and data scrambled while stalled
    send(8'h61, 1'b1, 1'b1);
    send(8'h62, 1'b1, 1'b1);
    send(8'h0C, 1'b1, 1'b1);
    send(8'h63, 1'b1, 1'b1);
    send(8'h64, 1'b0, 1'b1);
    wait_idle("ff");
    chk("ff_top", int'(top_row), 0);
    chk("ff_col", int'(cur_col), 2);
    chk("ff_row", int'(cur_row), 0);
    chk("ff_c_addr", last_wr(1), 0);
    chk("ff_d_addr", last_wr(0), 1);

    // Reset during the 30th scroll write
    for (int i = 0; i < 16; i++) send(8'h0A, 1'b0, 1'b0);
    wait_idle("lf_pre_reset");
    chk("pre_reset_row", int'(cur_row), 16);
    send(8'h0A, 1'b0, 1'b0);
    base_wr = wr_cnt;
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      #1;
      if (wr_cnt == base_wr + 30) hit = 1'b1;
    end
    chk("scroll30_reached", int'(hit), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_cea", int'(v_cea), 0);
    chk("abort_top", int'(top_row), 0);
    chk("abort_ready", int'(in_ready), 0);
    chk("abort_busy", int'(busy), 1);
    chk("abort_row", int'(cur_row), 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    base = wr_log.size();
    wait_idle("reclear");
    chk("reclear_first", (wr_log.size() > base) ? wr_log[base] : -1, 0);
    chk("reclear_count", wr_log.size() - base, 1020);
    chk("reclear_last", last_wr(0), 1019);

    send(8'h5A, 1'b0, 1'b0);
    wait_idle("final");
    chk("final_addr", last_wr(0), 0);
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
